// File: rtl/axi_trigger_queue_if.sv
`default_nettype none
//==============================================================================
// Module      : if_axi_light
// Description : AXI-lite bundle (32-bit address/data) with master/slave views.
// Revision    : 1.0 - initial release
//==============================================================================
interface if_axi_light;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface
`default_nettype wire

// File: rtl/axi_trigger_queue.sv
`default_nettype none
//==============================================================================
// Module      : axi_trigger_queue
// Description : Inline AXI-lite trigger decoder; trigger writes are queued as
//               host requests, other traffic passes through. Build macro
//               TRIG_TIMEOUT_EN adds a timeout on blocking triggers.
// Revision    : 1.0 - initial release
//==============================================================================
`ifndef FILE_TRIGGERS_BASE
`define FILE_TRIGGERS_BASE 32'h0000_1000
`endif

module axi_trigger_queue #(
    parameter int unsigned        N_TRIG         = 8,
    parameter logic [31:0]        TRIG_BASE      = `FILE_TRIGGERS_BASE,
    parameter int unsigned        DEPTH          = 4,
    parameter logic [N_TRIG-1:0]  POSTED_MASK    = '0,
    parameter int unsigned        TIMEOUT_CYC    = 4096,
    parameter int unsigned        AXI_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_offset,
    output logic                      req_valid,
    output logic [31:0]               req_op,
    output logic [31:0]               req_arg,
    output logic [31:0]               req_addr,
    input  logic                      req_ready,
    output logic [$clog2(DEPTH):0]    pending_count,
    output logic                      timeout_err,
    if_axi_light.slave                s_axi,
    if_axi_light.master               m_axi
);

    localparam int unsigned          c_PTR_W       = $clog2(DEPTH);
    localparam int unsigned          c_CNT_W       = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]   c_DEPTH       = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE     = c_PTR_W'(1);
    localparam logic [31:0]          c_SPAN        = 32'(4 * N_TRIG);
    localparam logic [15:0]          c_POSTED_MASK = 16'(POSTED_MASK);
    localparam logic [1:0]           c_OKAY        = 2'b00;
    localparam logic [1:0]           c_SLVERR      = 2'b10;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || N_TRIG < 1 || N_TRIG > 16
            || TIMEOUT_CYC < 1) begin : g_param_check
            $error("axi_trigger_queue: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DONE = 2'd1,
        S_RESP      = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_bresp;
    logic [1:0]          w_bresp_next;
    logic                w_flush;

    logic [31:0]         w_offset;
    logic                w_match;
    logic                w_hit;
    logic [3:0]          w_idx;
    logic                w_posted;
    logic [31:0]         w_push_op;
    logic [31:0]         w_push_arg;
    logic [31:0]         w_push_addr;

    logic [31:0]         r_mem_op   [DEPTH];
    logic [31:0]         r_mem_arg  [DEPTH];
    logic [31:0]         r_mem_addr [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  w_rd_ptr_next;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  w_count_next;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_head_is_push;

    logic                r_req_valid;
    logic [31:0]         r_req_op;
    logic [31:0]         r_req_arg;
    logic [31:0]         r_req_addr;

    // Trigger decode: an address outside the window wraps to a large offset.
    assign w_offset    = s_axi.awaddr - TRIG_BASE;
    assign w_match     = (w_offset < c_SPAN) && (w_offset[1:0] == 2'b00);
    assign w_hit       = s_axi.awvalid && s_axi.wvalid && w_match;
    assign w_idx       = w_offset[5:2];
    assign w_posted    = c_POSTED_MASK[w_idx];
    assign w_push_op   = 32'(w_idx) + 32'd1;
    assign w_push_arg  = s_axi.wdata + 32'(axi_offset);
    assign w_push_addr = s_axi.awaddr;

    assign w_full = (r_count == c_DEPTH);
    assign w_push = (r_state == S_IDLE) && w_hit && !w_full;
    assign w_pop  = req_ready && (r_count != '0);

    assign w_rd_ptr_next  = w_pop ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;
    assign w_head_is_push = (r_count == '0) || ((r_count == c_CNT_ONE) && w_pop);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_CNT_ONE;
        end
    end

`ifdef TRIG_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;
    logic        r_tmo_err;
    logic        w_tmo_expired;

    assign w_tmo_expired = (r_state == S_WAIT_DONE) && (r_tmo_cnt == 32'(TIMEOUT_CYC - 1));
    assign timeout_err   = r_tmo_err;

    // Held at zero outside WAIT_DONE, so it starts from zero on every entry.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            r_tmo_err <= w_flush;
            if (r_state == S_WAIT_DONE) begin
                r_tmo_cnt <= r_tmo_cnt + 32'd1;
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_bresp_next = r_bresp;
        w_flush      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_push) begin
                    w_state_next = w_posted ? S_RESP : S_WAIT_DONE;
                    w_bresp_next = c_OKAY;
                end
            end
            S_WAIT_DONE: begin
                // A drain in the expiry cycle still completes with OKAY.
                if (w_count_next == '0) begin
                    w_state_next = S_RESP;
                    w_bresp_next = c_OKAY;
                end
`ifdef TRIG_TIMEOUT_EN
                else if (w_tmo_expired) begin
                    w_state_next = S_RESP;
                    w_bresp_next = c_SLVERR;
                    w_flush      = 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (s_axi.bready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        m_axi.awaddr  = s_axi.awaddr;
        m_axi.awprot  = s_axi.awprot;
        m_axi.wdata   = s_axi.wdata;
        m_axi.wstrb   = s_axi.wstrb;
        m_axi.araddr  = s_axi.araddr;
        m_axi.arprot  = s_axi.arprot;
        s_axi.rdata   = m_axi.rdata;
        s_axi.rresp   = m_axi.rresp;
        m_axi.awvalid = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.bready  = 1'b0;
        m_axi.arvalid = 1'b0;
        m_axi.rready  = 1'b0;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        s_axi.bresp   = c_OKAY;
        s_axi.arready = 1'b0;
        s_axi.rvalid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                m_axi.arvalid = s_axi.arvalid;
                s_axi.arready = m_axi.arready;
                s_axi.rvalid  = m_axi.rvalid;
                m_axi.rready  = s_axi.rready;
                s_axi.bvalid  = m_axi.bvalid;
                s_axi.bresp   = m_axi.bresp;
                m_axi.bready  = s_axi.bready;
                // Trigger-window addresses never reach memory, even while W lags.
                if (s_axi.awvalid && w_match) begin
                    s_axi.awready = w_push;
                    s_axi.wready  = w_push;
                end else begin
                    m_axi.awvalid = s_axi.awvalid;
                    s_axi.awready = m_axi.awready;
                    m_axi.wvalid  = s_axi.wvalid;
                    s_axi.wready  = m_axi.wready;
                end
            end
            S_RESP: begin
                s_axi.bvalid = 1'b1;
                s_axi.bresp  = r_bresp;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr]   <= w_push_op;
            r_mem_arg[r_wr_ptr]  <= w_push_arg;
            r_mem_addr[r_wr_ptr] <= w_push_addr;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_state     <= S_IDLE;
            r_bresp     <= c_OKAY;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_req_valid <= 1'b0;
            r_req_op    <= '0;
            r_req_arg   <= '0;
            r_req_addr  <= '0;
        end else begin
            r_state <= w_state_next;
            r_bresp <= w_bresp_next;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                r_rd_ptr <= w_rd_ptr_next;
                r_count  <= w_count_next;
            end
            // Head registers track the entry that will be at the front after this edge.
            if (w_flush || (w_count_next == '0)) begin
                r_req_valid <= 1'b0;
                r_req_op    <= '0;
                r_req_arg   <= '0;
                r_req_addr  <= '0;
            end else if (w_head_is_push) begin
                r_req_valid <= 1'b1;
                r_req_op    <= w_push_op;
                r_req_arg   <= w_push_arg;
                r_req_addr  <= w_push_addr;
            end else begin
                r_req_valid <= 1'b1;
                r_req_op    <= r_mem_op[w_rd_ptr_next];
                r_req_arg   <= r_mem_arg[w_rd_ptr_next];
                r_req_addr  <= r_mem_addr[w_rd_ptr_next];
            end
        end
    end

    assign req_valid     = r_req_valid;
    assign req_op        = r_req_op;
    assign req_arg       = r_req_arg;
    assign req_addr      = r_req_addr;
    assign pending_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_axi_trigger_queue.sv
`default_nettype none
//==============================================================================
// Module      : tb_axi_trigger_queue
// Description : Self-checking bench for axi_trigger_queue (table vectors plus
//               FIFO, stall, wrap, timeout and reset sequences).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_axi_trigger_queue;

    localparam int unsigned N_TRIG      = 8;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam logic [31:0] BASE        = 32'h0000_1000;
    localparam logic [7:0]  PMASK       = 8'hF0;

    logic                   clk;
    logic                   res;
    logic [31:0]            axi_offset;
    logic                   req_valid;
    logic [31:0]            req_op;
    logic [31:0]            req_arg;
    logic [31:0]            req_addr;
    logic                   req_ready;
    logic [$clog2(DEPTH):0] pending_count;
    logic                   timeout_err;

    if_axi_light s_if ();
    if_axi_light m_if ();

    axi_trigger_queue #(
        .N_TRIG         (N_TRIG),
        .TRIG_BASE      (BASE),
        .DEPTH          (DEPTH),
        .POSTED_MASK    (PMASK),
        .TIMEOUT_CYC    (TIMEOUT_CYC),
        .AXI_ADDR_WIDTH (32)
    ) dut (
        .clk           (clk),
        .res           (res),
        .axi_offset    (axi_offset),
        .req_valid     (req_valid),
        .req_op        (req_op),
        .req_arg       (req_arg),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .pending_count (pending_count),
        .timeout_err   (timeout_err),
        .s_axi         (s_if),
        .m_axi         (m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        logic [31:0] arg;
        logic [31:0] addr;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] off;
        bit          hit;
        logic [31:0] op;
        bit          posted;
    } vec_t;

    req_t sb[$];
    vec_t vec[8];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic sb_compare(input string tag);
        req_t e;
        check($sformatf("%s req_valid", tag), 32'(req_valid), 32'd1);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got a pop, expected no queued request", tag);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s req_op", tag), req_op, e.op);
            check($sformatf("%s req_arg", tag), req_arg, e.arg);
            check($sformatf("%s req_addr", tag), req_addr, e.addr);
        end
    endtask

    task automatic host_pop(input string tag);
        @(negedge clk);
        req_ready = 1'b1;
        #1;
        sb_compare(tag);
        @(negedge clk);
        req_ready = 1'b0;
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [31:0] d);
        s_if.awaddr  = a;
        s_if.wdata   = d;
        s_if.awvalid = 1'b1;
        s_if.wvalid  = 1'b1;
    endtask

    task automatic end_write();
        s_if.awvalid = 1'b0;
        s_if.wvalid  = 1'b0;
    endtask

    task automatic posted_write(input logic [31:0] a, input logic [31:0] d, input string tag);
        @(negedge clk);
        drive_write(a, d);
        sb.push_back('{32'(((a - BASE) >> 2) + 1), d + axi_offset, a});
        #1;
        check($sformatf("%s awready", tag), 32'(s_if.awready), 32'd1);
        @(negedge clk);
        end_write();
        #1;
        check($sformatf("%s bvalid", tag), 32'(s_if.bvalid), 32'd1);
        check($sformatf("%s bresp", tag), 32'(s_if.bresp), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit early;

        vec[0] = '{32'h0000_0100, 32'h0000_00AB, 32'h0,    1'b0, 32'd0, 1'b0};
        vec[1] = '{32'h0000_1008, 32'h0000_0040, 32'h1000, 1'b1, 32'd3, 1'b0};
        vec[2] = '{32'h0000_1000, 32'hFFFF_FFFF, 32'h2,    1'b1, 32'd1, 1'b0};
        vec[3] = '{32'h0000_101C, 32'h0000_0005, 32'h0,    1'b1, 32'd8, 1'b1};
        vec[4] = '{32'h0000_1020, 32'h0000_0011, 32'h0,    1'b0, 32'd0, 1'b0};
        vec[5] = '{32'h0000_0FFC, 32'h0000_0022, 32'h0,    1'b0, 32'd0, 1'b0};
        vec[6] = '{32'h0000_1006, 32'h0000_0033, 32'h0,    1'b0, 32'd0, 1'b0};
        vec[7] = '{32'h0000_1010, 32'h1234_0000, 32'h5678, 1'b1, 32'd5, 1'b1};

        res          = 1'b1;
        axi_offset   = '0;
        req_ready    = 1'b0;
        s_if.awaddr  = '0;
        s_if.awprot  = '0;
        s_if.awvalid = 1'b0;
        s_if.wdata   = '0;
        s_if.wstrb   = 4'hF;
        s_if.wvalid  = 1'b0;
        s_if.bready  = 1'b1;
        s_if.araddr  = 32'h0000_0200;
        s_if.arprot  = '0;
        s_if.arvalid = 1'b0;
        s_if.rready  = 1'b1;
        m_if.awready = 1'b1;
        m_if.wready  = 1'b1;
        m_if.bvalid  = 1'b0;
        m_if.bresp   = 2'b00;
        m_if.arready = 1'b1;
        m_if.rdata   = '0;
        m_if.rresp   = '0;
        m_if.rvalid  = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("reset req_valid", 32'(req_valid), 32'd0);
        check("reset pending", 32'(pending_count), 32'd0);
        check("reset req_op", req_op, 32'd0);
        check("reset req_arg", req_arg, 32'd0);
        check("reset req_addr", req_addr, 32'd0);
        check("reset timeout_err", 32'(timeout_err), 32'd0);
        check("reset bvalid", 32'(s_if.bvalid), 32'd0);
        @(negedge clk);
        res = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            axi_offset = vec[i].off;
            drive_write(vec[i].addr, vec[i].data);
            if (vec[i].hit) sb.push_back('{vec[i].op, vec[i].data + vec[i].off, vec[i].addr});
            #1;
            check($sformatf("v%0d awready", i), 32'(s_if.awready), 32'd1);
            check($sformatf("v%0d m_awvalid", i), 32'(m_if.awvalid), 32'(!vec[i].hit));
            if (!vec[i].hit) begin
                check($sformatf("v%0d m_awaddr", i), m_if.awaddr, vec[i].addr);
                check($sformatf("v%0d m_wdata", i), m_if.wdata, vec[i].data);
            end
            @(negedge clk);
            end_write();
            #1;
            if (vec[i].hit) begin
                check($sformatf("v%0d pending", i), 32'(pending_count), 32'd1);
                check($sformatf("v%0d bvalid", i), 32'(s_if.bvalid), 32'(vec[i].posted));
                if (!vec[i].posted) begin
                    s_if.arvalid = 1'b1;
                    #1;
                    check($sformatf("v%0d m_arvalid", i), 32'(m_if.arvalid), 32'd0);
                    check($sformatf("v%0d arready", i), 32'(s_if.arready), 32'd0);
                    s_if.arvalid = 1'b0;
                    host_pop($sformatf("v%0d pop", i));
                    #1;
                    check($sformatf("v%0d blk bvalid", i), 32'(s_if.bvalid), 32'd1);
                    check($sformatf("v%0d blk bresp", i), 32'(s_if.bresp), 32'd0);
                    check($sformatf("v%0d drained", i), 32'(pending_count), 32'd0);
                end else begin
                    check($sformatf("v%0d bresp", i), 32'(s_if.bresp), 32'd0);
                    host_pop($sformatf("v%0d pop", i));
                end
            end else begin
                m_if.bvalid = 1'b1;
                m_if.bresp  = 2'b01;
                #1;
                check($sformatf("v%0d pass bvalid", i), 32'(s_if.bvalid), 32'd1);
                check($sformatf("v%0d pass bresp", i), 32'(s_if.bresp), 32'd1);
                check($sformatf("v%0d no push", i), 32'(pending_count), 32'd0);
                @(negedge clk);
                m_if.bvalid = 1'b0;
                m_if.bresp  = 2'b00;
            end
        end

        // Fill the FIFO with posted triggers while the host is idle.
        axi_offset = 32'h0000_0010;
        for (int k = 0; k < int'(DEPTH); k++) begin
            posted_write(BASE + 32'(4 * (4 + k)), 32'h100 + 32'(k), $sformatf("fill%0d", k));
        end
        check("fill pending", 32'(pending_count), 32'(DEPTH));

        @(negedge clk);
        drive_write(BASE + 32'h18, 32'h555);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("full awready c%0d", c), 32'(s_if.awready), 32'd0);
            check($sformatf("full m_awvalid c%0d", c), 32'(m_if.awvalid), 32'd0);
            @(negedge clk);
        end
        req_ready = 1'b1;
        #1;
        sb_compare("full pop");
        check("full pop awready", 32'(s_if.awready), 32'd0);
        @(negedge clk);
        req_ready = 1'b0;
        #1;
        check("unstall awready", 32'(s_if.awready), 32'd1);
        sb.push_back('{32'd7, 32'h555 + 32'h10, BASE + 32'h18});
        @(negedge clk);
        end_write();
        #1;
        check("refill pending", 32'(pending_count), 32'(DEPTH));
        check("refill bvalid", 32'(s_if.bvalid), 32'd1);

        host_pop("pre-simul 0");
        host_pop("pre-simul 1");
        #1;
        check("simul start count", 32'(pending_count), 32'd2);
        @(negedge clk);
        drive_write(BASE + 32'h1C, 32'h777);
        req_ready = 1'b1;
        #1;
        check("simul awready", 32'(s_if.awready), 32'd1);
        sb_compare("simul pop");
        sb.push_back('{32'd8, 32'h777 + 32'h10, BASE + 32'h1C});
        @(negedge clk);
        end_write();
        req_ready = 1'b0;
        #1;
        check("simul count", 32'(pending_count), 32'd2);
        host_pop("wrap 0");
        host_pop("wrap 1");
        #1;
        check("wrap drained", 32'(pending_count), 32'd0);
        check("wrap req_valid", 32'(req_valid), 32'd0);

`ifdef TRIG_TIMEOUT_EN
        axi_offset = '0;
        @(negedge clk);
        drive_write(BASE + 32'h4, 32'h9);
        #1;
        check("tmo awready", 32'(s_if.awready), 32'd1);
        @(negedge clk);
        end_write();
        early = 1'b0;
        for (int c = 1; c <= int'(TIMEOUT_CYC); c++) begin
            @(negedge clk);
            #1;
            if (c < int'(TIMEOUT_CYC) && timeout_err) early = 1'b1;
        end
        check("tmo early pulse", 32'(early), 32'd0);
        check("tmo pulse", 32'(timeout_err), 32'd1);
        check("tmo bvalid", 32'(s_if.bvalid), 32'd1);
        check("tmo bresp", 32'(s_if.bresp), 32'd2);
        check("tmo flushed", 32'(pending_count), 32'd0);
        check("tmo req_valid", 32'(req_valid), 32'd0);
        @(negedge clk);
        #1;
        check("tmo pulse end", 32'(timeout_err), 32'd0);
`else
        axi_offset = '0;
        @(negedge clk);
        drive_write(BASE + 32'h4, 32'h9);
        sb.push_back('{32'd2, 32'h9, BASE + 32'h4});
        #1;
        check("wait awready", 32'(s_if.awready), 32'd1);
        @(negedge clk);
        end_write();
        early = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (s_if.bvalid || timeout_err) early = 1'b1;
        end
        check("wait no response", 32'(early), 32'd0);
        check("wait pending", 32'(pending_count), 32'd1);
        host_pop("wait pop");
        #1;
        check("wait bvalid", 32'(s_if.bvalid), 32'd1);
        check("wait bresp", 32'(s_if.bresp), 32'd0);
`endif
        sb.delete();

        // Hold the third posted response in RESP with three entries queued, then reset.
        axi_offset = '0;
        posted_write(BASE + 32'h10, 32'hA1, "rst w0");
        posted_write(BASE + 32'h14, 32'hA2, "rst w1");
        @(negedge clk);
        s_if.bready = 1'b0;
        @(negedge clk);
        end_write();
        posted_write(BASE + 32'h18, 32'hA3, "rst w2");
        @(negedge clk);
        #1;
        check("rst pre bvalid", 32'(s_if.bvalid), 32'd1);
        check("rst pre pending", 32'(pending_count), 32'd3);
        res = 1'b1;
        #1;
        check("rst req_valid", 32'(req_valid), 32'd0);
        check("rst pending", 32'(pending_count), 32'd0);
        check("rst bvalid", 32'(s_if.bvalid), 32'd0);
        check("rst req_op", req_op, 32'd0);
        check("rst timeout_err", 32'(timeout_err), 32'd0);
        sb.delete();
        @(negedge clk);
        res         = 1'b0;
        s_if.bready = 1'b1;
        @(negedge clk);
        s_if.arvalid = 1'b1;
        #1;
        check("post-rst pending", 32'(pending_count), 32'd0);
        check("post-rst bvalid", 32'(s_if.bvalid), 32'd0);
        check("post-rst m_arvalid", 32'(m_if.arvalid), 32'd1);
        check("post-rst arready", 32'(s_if.arready), 32'd1);
        s_if.arvalid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
